// File: rtl/decode_stage_pipe.sv
// Instruction-decode stage: register file, immediate sign-extension, control decode, load-use
// stall and the ID/EX pipeline register. Define DECODE_WB_BYPASS_EN for write-through reads.
module decode_stage_pipe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [15:0]       if_instr,
    input  logic              ex_flush,
    input  logic              ex_hold,
    input  logic              wb_reg_write,
    input  logic [2:0]        wb_write_reg,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_read_data_1,
    output logic [DATA_W-1:0] ex_read_data_2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [2:0]        ex_rs,
    output logic [2:0]        ex_rt,
    output logic [2:0]        ex_rd,
    output logic              ex_reg_dst,
    output logic              ex_alu_src,
    output logic              ex_mem_to_reg,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_branch,
    output logic [1:0]        ex_alu_op,
    output logic              ex_illegal
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [2:0]        rs;
        logic [2:0]        rt;
        logic [2:0]        rd;
        logic              reg_dst;
        logic              alu_src;
        logic              mem_to_reg;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic [1:0]        alu_op;
        logic              illegal;
    } id_ex_t;

    logic [2:0]        opcode, rs, rt, rd;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] read_data_1, read_data_2;
    logic              rs_used, rt_used, load_use;
    id_ex_t            dec, id_ex_d, id_ex_q;

    assign opcode = if_instr[15:13];
    assign rs     = if_instr[12:10];
    assign rt     = if_instr[9:7];
    assign rd     = if_instr[6:4];

    // Register file; R0 is never written so it always reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_reg_write && (wb_write_reg != 3'd0)) begin
            regs_q[wb_write_reg] <= wb_write_data;
        end
    end

    always_comb begin
        read_data_1 = (rs == 3'd0) ? '0 : regs_q[rs];
        read_data_2 = (rt == 3'd0) ? '0 : regs_q[rt];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_reg_write && (wb_write_reg != 3'd0) && (wb_write_reg == rs)) begin
            read_data_1 = wb_write_data;
        end
        if (wb_reg_write && (wb_write_reg != 3'd0) && (wb_write_reg == rt)) begin
            read_data_2 = wb_write_data;
        end
`endif
    end

    always_comb begin
        dec        = '0;
        dec.valid  = 1'b1;
        dec.rd1    = read_data_1;
        dec.rd2    = read_data_2;
        dec.imm    = {{(DATA_W - IMM_W){if_instr[IMM_W-1]}}, if_instr[IMM_W-1:0]};
        dec.rs     = rs;
        dec.rt     = rt;
        dec.rd     = rd;
        rs_used    = 1'b1;
        rt_used    = 1'b0;
        unique case (opcode)
            3'b000: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 2'b10;
                rt_used       = 1'b1;
            end
            3'b001: begin
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
            end
            3'b010: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                rt_used       = 1'b1;
            end
            3'b011: begin
                dec.branch = 1'b1;
                dec.alu_op = 2'b01;
                rt_used    = 1'b1;
            end
            3'b100: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: begin
                dec.illegal = 1'b1;
                rs_used     = 1'b0;
            end
        endcase
    end

    // Load in ID/EX whose destination is a source operand of the instruction in IF/ID.
    assign load_use = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rt != 3'd0) && if_valid &&
                      (((id_ex_q.rt == rs) && rs_used) || ((id_ex_q.rt == rt) && rt_used));

    assign id_stall = !rst && !ex_flush && (ex_hold || load_use);

    always_comb begin
        id_ex_d = id_ex_q;
        if (ex_flush) begin
            id_ex_d = '0;
        end else if (ex_hold) begin
            id_ex_d = id_ex_q;
        end else if (load_use || !if_valid) begin
            id_ex_d = '0;
        end else begin
            id_ex_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign ex_valid       = id_ex_q.valid;
    assign ex_read_data_1 = id_ex_q.rd1;
    assign ex_read_data_2 = id_ex_q.rd2;
    assign ex_imm         = id_ex_q.imm;
    assign ex_rs          = id_ex_q.rs;
    assign ex_rt          = id_ex_q.rt;
    assign ex_rd          = id_ex_q.rd;
    assign ex_reg_dst     = id_ex_q.reg_dst;
    assign ex_alu_src     = id_ex_q.alu_src;
    assign ex_mem_to_reg  = id_ex_q.mem_to_reg;
    assign ex_reg_write   = id_ex_q.reg_write;
    assign ex_mem_read    = id_ex_q.mem_read;
    assign ex_mem_write   = id_ex_q.mem_write;
    assign ex_branch      = id_ex_q.branch;
    assign ex_alu_op      = id_ex_q.alu_op;
    assign ex_illegal     = id_ex_q.illegal;

endmodule
